payload_arbiter: RTL and testbench
==================================

PAYLOAD_ARBITER -- requirements
Module: payload_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of requesters sharing the payload buffer (range 2..8).
REQ-002 Parameter MAX_BURST, default 64, watchdog limit in beats per granted burst (range 2..255).
REQ-003 Port clock  input  1  the single clock; all logic is on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req  input  NUM_PORTS  per-requester access request, held high for the whole burst.
REQ-006 Port reqWrite  input  NUM_PORTS  per-requester direction: 1 = write burst, 0 = read burst.
REQ-007 Port wrLast  input  NUM_PORTS  per-requester final-beat marker for a write burst.
REQ-008 Port rdLast  input  1  the buffer read bus isLast, marking the final beat of a read burst.
REQ-009 Port grant  output  NUM_PORTS  one-hot grant; all zero when no burst is active.
REQ-010 Port grantIndex  output  $clog2(NUM_PORTS)  binary index of the current or last granted port.
REQ-011 Port pbEnable  output  1  drives the buffer enable.
REQ-012 Port pbReadWrite  output  1  drives the buffer readWrite (1 = write).
REQ-013 Port busy  output  1  high while in state BURST.
REQ-014 Port abortPulse  output  1  one-cycle pulse when a burst is terminated abnormally.

Function
REQ-015 FSM states: IDLE, BURST, GAP; all outputs are registered.
REQ-016 In IDLE or GAP with any req bit high, the arbiter picks a winner round-robin and enters BURST next cycle.
REQ-017 Round-robin: search starts at port (last grantIndex + 1) mod NUM_PORTS; after reset the search starts at port 0.
REQ-018 Latency: req sampled high at edge t gives grant, pbEnable and busy high from edge t+1.
REQ-019 reqWrite[winner] is captured at the grant and drives pbReadWrite, which stays constant for the whole burst.
REQ-020 In BURST, pbEnable = 1 and grant = onehot(grantIndex); a beat counter increments once per cycle starting at 1.
REQ-021 Write burst ends on the BURST cycle where wrLast[grantIndex] = 1; read burst ends on the BURST cycle where rdLast = 1.
REQ-022 A normal end moves to GAP next cycle; in GAP pbEnable = 0, grant = 0 and abortPulse = 0.
REQ-023 Consecutive bursts are always separated by at least one GAP cycle with pbEnable low.
REQ-024 With GAP and no req high, the next state is IDLE.
REQ-025 Watchdog: if the beat counter reaches MAX_BURST with no final beat, the burst is aborted.
REQ-026 Requester drop: if req[grantIndex] falls during BURST, the burst is aborted in that same cycle.
REQ-027 On abort, the next state is GAP and abortPulse is high for exactly that GAP cycle.
REQ-028 If a final beat and an abort occur in the same cycle, the burst counts as a normal end and no abortPulse is issued.
REQ-029 req and reqWrite changes from non-granted ports during BURST have no effect until the next arbitration.
REQ-030 pbReadWrite holds its last value outside BURST; grantIndex holds its last value outside BURST.

Reset
REQ-031 While reset is high at an edge: state = IDLE, grant = 0, grantIndex = 0, pbEnable = 0, pbReadWrite = 0, busy = 0, abortPulse = 0, beat counter = 0, round-robin pointer = 0.
REQ-032 Reset asserted mid-burst takes effect at the next edge; no abortPulse is generated for a burst killed by reset.

Structure
REQ-033 The state enum type and the MAX_BURST default constant belong in the shared PayloadBus package.
REQ-034 Round-robin selection is one combinational sub-module, rr_picker (inputs: request vector and start index; outputs: valid and winner index).
REQ-035 Beat counter width is $clog2(MAX_BURST+1); the counter saturates and never wraps.

Verification
REQ-036 After reset, req=0001 with reqWrite[0]=1 and wrLast[0] high on beat 4 -> grant=0001 and pbEnable=1 for 4 cycles, pbReadWrite=1, then one GAP cycle, then IDLE.
REQ-037 req=1111 held continuously, each burst 2 beats -> grantIndex sequence 0,1,2,3,0 with exactly one GAP cycle between bursts.
REQ-038 Port 2 read (reqWrite[2]=0) with rdLast high on beat 3 -> pbReadWrite=0, three enabled cycles, then GAP; abortPulse stays 0.
REQ-039 MAX_BURST=8, port 1 write with wrLast never high -> pbEnable for 8 cycles, then abortPulse=1 in the GAP cycle; port 2 is granted next if it is requesting.
REQ-040 req[3] dropped on beat 2 of a burst -> abortPulse in the following cycle; then reset asserted on beat 2 of a new burst -> all outputs 0 on the next edge and no abortPulse.

Source files
------------

// File: rtl/payload_bus_pkg.sv
// Shared types and defaults for the payload buffer arbiter.
// Holds the arbiter state encoding and the round-robin wrap helper.
package payload_bus_pkg;

    localparam int unsigned NUM_PORTS_DEFAULT = 4;
    localparam int unsigned MAX_BURST_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    // Port following idx, wrapping at num_ports.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_ports);
        return (idx + 1 >= num_ports) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/payload_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting port at or after i_start.
// The search wraps modulo NUM_PORTS.
module rr_picker
    import payload_bus_pkg::*;
#(
    parameter  int unsigned NUM_PORTS = NUM_PORTS_DEFAULT,
    localparam int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_start,
    output logic                 o_valid,
    output logic [IDX_W-1:0]     o_winner
);

    int unsigned w_idx;

    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_idx    = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            w_idx = (32'(i_start) + i) % NUM_PORTS;
            if (!o_valid && i_req[IDX_W'(w_idx)]) begin
                o_valid  = 1'b1;
                o_winner = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/payload_arbiter.sv
// Round-robin arbiter granting one requester at a time a burst on the payload buffer.
// Bursts end on a final beat, a requester drop or the beat watchdog; a GAP cycle follows each.
module payload_arbiter
    import payload_bus_pkg::*;
#(
    parameter  int unsigned NUM_PORTS = NUM_PORTS_DEFAULT,
    parameter  int unsigned MAX_BURST = MAX_BURST_DEFAULT,
    localparam int unsigned IDX_W     = $clog2(NUM_PORTS),
    localparam int unsigned BEAT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] reqWrite,
    input  logic [NUM_PORTS-1:0] wrLast,
    input  logic                 rdLast,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grantIndex,
    output logic                 pbEnable,
    output logic                 pbReadWrite,
    output logic                 busy,
    output logic                 abortPulse
);

    arb_state_e           r_state,     w_state_nxt;
    logic [NUM_PORTS-1:0] r_grant,     w_grant_nxt;
    logic [IDX_W-1:0]     r_grant_idx, w_grant_idx_nxt;
    logic [IDX_W-1:0]     r_rr_ptr,    w_rr_ptr_nxt;
    logic                 r_pb_en,     w_pb_en_nxt;
    logic                 r_pb_rw,     w_pb_rw_nxt;
    logic                 r_busy,      w_busy_nxt;
    logic                 r_abort,     w_abort_nxt;
    logic [BEAT_W-1:0]    r_beat,      w_beat_nxt;

    logic                 w_pick_valid;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_final;
    logic                 w_drop;
    logic                 w_wdog;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_picker (
        .i_req    (req),
        .i_start  (r_rr_ptr),
        .o_valid  (w_pick_valid),
        .o_winner (w_pick_idx)
    );

    // Burst termination terms; only meaningful while in BURST.
    assign w_final = r_pb_rw ? wrLast[r_grant_idx] : rdLast;
    assign w_drop  = ~req[r_grant_idx];
    assign w_wdog  = (r_beat >= BEAT_W'(MAX_BURST));

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_grant_idx_nxt = r_grant_idx;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_pb_en_nxt     = r_pb_en;
        w_pb_rw_nxt     = r_pb_rw;
        w_busy_nxt      = r_busy;
        w_abort_nxt     = 1'b0;
        w_beat_nxt      = r_beat;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (w_pick_valid) begin
                    w_state_nxt     = ST_BURST;
                    w_grant_nxt     = NUM_PORTS'(1) << w_pick_idx;
                    w_grant_idx_nxt = w_pick_idx;
                    w_rr_ptr_nxt    = IDX_W'(rr_next(32'(w_pick_idx), NUM_PORTS));
                    w_pb_en_nxt     = 1'b1;
                    w_pb_rw_nxt     = reqWrite[w_pick_idx];
                    w_busy_nxt      = 1'b1;
                    w_beat_nxt      = BEAT_W'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_pb_en_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_beat_nxt  = '0;
                end
            end
            ST_BURST: begin
                // A final beat wins over any simultaneous abort cause.
                if (w_final || w_drop || w_wdog) begin
                    w_state_nxt = ST_GAP;
                    w_grant_nxt = '0;
                    w_pb_en_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_beat_nxt  = '0;
                    w_abort_nxt = ~w_final;
                end else if (r_beat < BEAT_W'(MAX_BURST)) begin
                    w_beat_nxt = r_beat + BEAT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_pb_en_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                w_beat_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_pb_en     <= 1'b0;
            r_pb_rw     <= 1'b0;
            r_busy      <= 1'b0;
            r_abort     <= 1'b0;
            r_beat      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_pb_en     <= w_pb_en_nxt;
            r_pb_rw     <= w_pb_rw_nxt;
            r_busy      <= w_busy_nxt;
            r_abort     <= w_abort_nxt;
            r_beat      <= w_beat_nxt;
        end
    end

    assign grant       = r_grant;
    assign grantIndex  = r_grant_idx;
    assign pbEnable    = r_pb_en;
    assign pbReadWrite = r_pb_rw;
    assign busy        = r_busy;
    assign abortPulse  = r_abort;

endmodule

// File: tb/tb_payload_arbiter.sv
// Scoreboard bench for payload_arbiter: a timeline driver predicts each burst
// (winner, direction, length, abort) and a negedge monitor checks observed bursts.
module tb_payload_arbiter;

    localparam int NP = 4;
    localparam int IW = 2;
    localparam int MB = 8;

    logic          clock    = 1'b0;
    logic          reset    = 1'b1;
    logic [NP-1:0] req      = '0;
    logic [NP-1:0] reqWrite = '0;
    logic [NP-1:0] wrLast   = '0;
    logic          rdLast   = 1'b0;
    logic [NP-1:0] grant;
    logic [IW-1:0] grantIndex;
    logic          pbEnable;
    logic          pbReadWrite;
    logic          busy;
    logic          abortPulse;

    payload_arbiter #(
        .NUM_PORTS (NP),
        .MAX_BURST (MB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .reqWrite    (reqWrite),
        .wrLast      (wrLast),
        .rdLast      (rdLast),
        .grant       (grant),
        .grantIndex  (grantIndex),
        .pbEnable    (pbEnable),
        .pbReadWrite (pbReadWrite),
        .busy        (busy),
        .abortPulse  (abortPulse)
    );

    always #5 clock = ~clock;

    typedef struct {
        int port;
        bit wr;
        int beats;
        bit abort;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   m_ptr  = 0;

    logic          rst_q     = 1'b1;
    bit            mon_in    = 1'b0;
    int            mon_beats = 0;
    logic [IW-1:0] mon_idx   = '0;
    logic          mon_rw    = 1'b0;
    exp_t          mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [NP-1:0] v, input int p);
        return v[p[IW-1:0]];
    endfunction

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_zero_outputs();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_grantIndex", 32'(grantIndex), 0);
        chk("rst_pbEnable", 32'(pbEnable), 0);
        chk("rst_pbReadWrite", 32'(pbReadWrite), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_abortPulse", 32'(abortPulse), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; reqWrite = '0; wrLast = '0; rdLast = 1'b0;
        cycle();
        chk_zero_outputs();
        reset = 1'b0;
        m_ptr = 0;
    endtask

    task automatic idle(input int n);
        req = '0; reqWrite = NP'($urandom); wrLast = NP'($urandom); rdLast = 1'($urandom);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // mode: 0 final beat, 1 requester drop, 2 watchdog, 3 drop together with final beat
    task automatic run_burst(input logic [NP-1:0] mask, input logic [NP-1:0] rw,
                             input int len, input int mode);
        int   w;
        int   nb;
        bit   wr;
        exp_t e;
        w = 0;
        for (int i = NP - 1; i >= 0; i--) begin
            if (bit_of(mask, (m_ptr + i) % NP)) w = (m_ptr + i) % NP;
        end
        m_ptr   = (w + 1) % NP;
        wr      = bit_of(rw, w);
        nb      = (mode == 2) ? MB : len;
        e.port  = w;
        e.wr    = wr;
        e.beats = nb;
        e.abort = (mode == 1 || mode == 2);
        sb.push_back(e);
        req = mask; reqWrite = rw; wrLast = NP'($urandom); rdLast = 1'($urandom);
        cycle();
        for (int k = 1; k <= nb; k++) begin
            bit fin;
            bit drop;
            fin  = (k == nb) && (mode == 0 || mode == 3);
            drop = (k == nb) && (mode == 1 || mode == 3);
            req = NP'($urandom);
            req[w[IW-1:0]] = !drop;
            reqWrite = NP'($urandom);
            wrLast   = NP'($urandom);
            rdLast   = 1'($urandom);
            if (wr) wrLast[w[IW-1:0]] = fin;
            else    rdLast = fin;
            cycle();
        end
    endtask

    always @(posedge clock) rst_q <= reset;

    // Monitor: tracks enabled runs and scores each one in the GAP cycle after it.
    always @(negedge clock) begin
        if (rst_q) begin
            mon_in = 1'b0;
        end else if (pbEnable) begin
            if (!mon_in) begin
                mon_in    = 1'b1;
                mon_beats = 1;
                mon_idx   = grantIndex;
                mon_rw    = pbReadWrite;
            end else begin
                mon_beats++;
                chk("idx_stable", 32'(grantIndex), 32'(mon_idx));
                chk("rw_stable", 32'(pbReadWrite), 32'(mon_rw));
            end
            chk("grant_onehot", 32'(grant), 32'(NP'(1) << mon_idx));
            chk("busy_burst", 32'(busy), 1);
            chk("abort_in_burst", 32'(abortPulse), 0);
        end else if (mon_in) begin
            mon_in = 1'b0;
            if (sb.size() == 0) begin
                chk("unexpected_burst", 32'(mon_beats), 0);
            end else begin
                mon_e = sb.pop_front();
                chk("burst_port", 32'(mon_idx), 32'(mon_e.port));
                chk("burst_dir", 32'(mon_rw), 32'(mon_e.wr));
                chk("burst_beats", 32'(mon_beats), 32'(mon_e.beats));
                chk("gap_abort", 32'(abortPulse), 32'(mon_e.abort));
                chk("gap_idx_hold", 32'(grantIndex), 32'(mon_e.port));
                chk("gap_rw_hold", 32'(pbReadWrite), 32'(mon_e.wr));
            end
            chk("gap_grant", 32'(grant), 0);
            chk("gap_busy", 32'(busy), 0);
        end else begin
            chk("idle_grant", 32'(grant), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_abort", 32'(abortPulse), 0);
        end
    end

    initial begin
        do_reset();
        run_burst(4'b0001, 4'b0001, 4, 0);
        idle(3);

        do_reset();
        for (int i = 0; i < 5; i++) run_burst(4'b1111, NP'($urandom), 2, 0);
        idle(2);

        run_burst(4'b0100, 4'b0000, 3, 0);
        idle(1);
        run_burst(4'b0110, 4'b0010, 0, 2);
        run_burst(4'b0100, 4'b0000, 2, 0);
        run_burst(4'b1000, 4'b1000, 2, 1);
        idle(2);

        // Reset on beat 2 of a burst: no scoreboard entry, outputs must clear.
        req = 4'b1000; reqWrite = 4'b1000; wrLast = '0; rdLast = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        chk_zero_outputs();
        reset = 1'b0; req = '0; reqWrite = '0;
        m_ptr = 0;
        cycle();
        chk("midrst_no_abort", 32'(abortPulse), 0);
        chk("midrst_no_enable", 32'(pbEnable), 0);

        for (int n = 0; n < 200; n++) begin
            int mode;
            int len;
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
            mode = int'($urandom_range(0, 9));
            mode = (mode < 5) ? 0 : (mode < 7) ? 1 : (mode < 8) ? 2 : 3;
            len  = int'($urandom_range(1, MB));
            run_burst(NP'($urandom_range(1, 15)), NP'($urandom), len, mode);
        end
        idle(3);

        chk("sb_empty", 32'(sb.size()), 0);
        chk("mon_idle", 32'(mon_in), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
